// File: rtl/spectrum_averager_if.sv
// spectrum_averager_if: FFT input stream and reduced-power output stream
interface spectrum_averager_if #(
   parameter int DATA_W = 38,
   parameter int OUT_W  = 32
);
   logic [2*DATA_W-1:0] s_axis_tdata;
   logic                s_axis_tvalid;
   logic                s_axis_tready;
   logic                s_axis_tlast;
   logic [OUT_W-1:0]    m_axis_tdata;
   logic                m_axis_tvalid;
   logic                m_axis_tready;
   logic                m_axis_tlast;
   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
endinterface

// File: rtl/spectrum_averager.sv
// spectrum_averager: per-bin power, mean or peak-hold over 2^NUM_FRAMES_LOG2 frames,
// scaled/saturated/byte-swapped reduced frame out on an AXI-stream
module spectrum_averager #(
   parameter int DATA_W          = 38,
   parameter int FRAME_BINS      = 256,
   parameter int NUM_FRAMES_LOG2 = 2,
   parameter int MODE            = 0,
   parameter int OUT_W           = 32,
   parameter int OUT_LSB         = 44,
   parameter int BYTE_SWAP       = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   spectrum_averager_if.slave   bus,
   output logic                 frame_err
);
   localparam int PW    = 2*DATA_W + 1;
   localparam int ACC_W = PW + NUM_FRAMES_LOG2;
   localparam int BW    = $clog2(FRAME_BINS);
   localparam int FW    = NUM_FRAMES_LOG2 > 0 ? NUM_FRAMES_LOG2 : 1;
   localparam logic [BW-1:0] LAST_BIN = BW'(FRAME_BINS - 1);
   localparam logic [FW-1:0] LAST_FRM = FW'((1 << NUM_FRAMES_LOG2) - 1);

   logic rdy, en, acc_beat, at_last, err;
   logic v1, v2, first1, first2, emit1, emit2;
   logic [BW-1:0] bin_cnt, bin1, bin2;
   logic [FW-1:0] frame_cnt;
   logic signed [DATA_W-1:0] re, im;
   logic signed [2*DATA_W-1:0] re_w, im_w, sq_re, sq_im;
   logic [PW-1:0] pwr;
   logic [ACC_W-1:0] ram [FRAME_BINS];
   logic [ACC_W-1:0] rd1, rd2, acc, r;
   logic [OUT_W-1:0] sat, swp;

   assign en = !bus.m_axis_tvalid | bus.m_axis_tready;
   assign bus.s_axis_tready = rdy & en;
   assign acc_beat = bus.s_axis_tvalid & bus.s_axis_tready;
   assign at_last = bin_cnt == LAST_BIN;
   assign err = bus.s_axis_tlast != at_last;
   assign {im, re} = bus.s_axis_tdata;
   assign re_w = (2*DATA_W)'(re);
   assign im_w = (2*DATA_W)'(im);

   always_comb begin
      acc = first2 ? ACC_W'(pwr) :
            MODE == 1 ? (rd2 > ACC_W'(pwr) ? rd2 : ACC_W'(pwr)) : rd2 + ACC_W'(pwr);
      r = MODE == 1 ? acc : acc >> NUM_FRAMES_LOG2;
      sat = |(r >> (OUT_LSB + OUT_W)) ? '1 : r[OUT_LSB +: OUT_W];
      swp = sat;
      for (int i = 0; i < OUT_W/8; i++) swp[8*i +: 8] = sat[OUT_W-8-8*i +: 8];
   end

   // The RAM is read at acceptance and written two enables later; the next read of
   // the same bin is at least FRAME_BINS beats away, so no forwarding is needed.
   always_ff @(posedge clk) begin
      if (en) begin
         sq_re  <= re_w * re_w;
         sq_im  <= im_w * im_w;
         rd1    <= ram[bin_cnt];
         bin1   <= bin_cnt;
         first1 <= frame_cnt == '0;
         emit1  <= frame_cnt == LAST_FRM;
         pwr    <= PW'($unsigned(sq_re)) + PW'($unsigned(sq_im));
         rd2    <= rd1;
         bin2   <= bin1;
         first2 <= first1;
         emit2  <= emit1;
         if (v2) ram[bin2] <= acc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy               <= 1'b0;
         bin_cnt           <= '0;
         frame_cnt         <= '0;
         v1                <= 1'b0;
         v2                <= 1'b0;
         frame_err         <= 1'b0;
         bus.m_axis_tvalid <= 1'b0;
         bus.m_axis_tlast  <= 1'b0;
         bus.m_axis_tdata  <= '0;
      end else begin
         rdy       <= 1'b1;
         frame_err <= acc_beat & !clear & err;
         if (clear || (acc_beat && err)) begin
            bin_cnt   <= '0;
            frame_cnt <= '0;
         end else if (acc_beat) begin
            bin_cnt <= at_last ? '0 : bin_cnt + 1'b1;
            if (at_last) frame_cnt <= frame_cnt == LAST_FRM ? '0 : frame_cnt + 1'b1;
         end
         if (en) begin
            v1                <= acc_beat & !clear & !err;
            v2                <= v1;
            bus.m_axis_tvalid <= v2 & emit2;
            if (v2 & emit2) begin
               bus.m_axis_tdata <= BYTE_SWAP != 0 ? swp : sat;
               bus.m_axis_tlast <= bin2 == LAST_BIN;
            end
         end
      end
   end
endmodule

// File: tb/tb_spectrum_averager.sv
// tb_spectrum_averager: three configurations on one stimulus stream, checked
// against a per-bin reference model through scoreboard queues
module tb_spectrum_averager;
   logic clk = 1'b0;
   logic rst_n, clear, tvalid, tlast, m_tready;
   logic [75:0] tdata;
   logic fe0, fe1, fe2;

   spectrum_averager_if #(.DATA_W(38), .OUT_W(32)) b0 ();
   spectrum_averager_if #(.DATA_W(38), .OUT_W(32)) b1 ();
   spectrum_averager_if #(.DATA_W(38), .OUT_W(8))  b2 ();

   assign b0.s_axis_tdata = tdata;  assign b1.s_axis_tdata = tdata;  assign b2.s_axis_tdata = tdata;
   assign b0.s_axis_tvalid = tvalid; assign b1.s_axis_tvalid = tvalid; assign b2.s_axis_tvalid = tvalid;
   assign b0.s_axis_tlast = tlast;  assign b1.s_axis_tlast = tlast;  assign b2.s_axis_tlast = tlast;
   assign b0.m_axis_tready = m_tready; assign b1.m_axis_tready = m_tready; assign b2.m_axis_tready = m_tready;

   spectrum_averager #(.DATA_W(38), .FRAME_BINS(256), .NUM_FRAMES_LOG2(2), .MODE(0),
      .OUT_W(32), .OUT_LSB(0), .BYTE_SWAP(0)) u0 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(b0.slave), .frame_err(fe0));
   spectrum_averager #(.DATA_W(38), .FRAME_BINS(256), .NUM_FRAMES_LOG2(2), .MODE(1),
      .OUT_W(32), .OUT_LSB(0), .BYTE_SWAP(1)) u1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(b1.slave), .frame_err(fe1));
   spectrum_averager #(.DATA_W(38), .FRAME_BINS(256), .NUM_FRAMES_LOG2(2), .MODE(0),
      .OUT_W(8), .OUT_LSB(2), .BYTE_SWAP(0)) u2 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(b2.slave), .frame_err(fe2));

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   int cyc = 0, out_cnt = 0, last_cnt = 0, err_cnt = 0, first_cyc = -1, acc0 = 0;
   int mbin = 0, mframe = 0;
   logic [78:0] sum_m [256];
   logic [78:0] max_m [256];
   logic [32:0] q0[$], q1[$], q2[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fmt(input logic [78:0] r, input int w, input int lsb, input bit swap);
      logic [78:0] sh;
      logic [31:0] v;
      sh = r >> lsb;
      v = (sh >> w) != 0 ? (w == 32 ? 32'hFFFF_FFFF : 32'h0000_00FF) : 32'(sh) & ((w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF);
      if (swap) v = {v[7:0], v[15:8], v[23:16], v[31:24]};
      return v;
   endfunction

   task automatic model_accept(input logic signed [37:0] re, input logic signed [37:0] im, input logic last);
      logic signed [78:0] rw, iw;
      logic [78:0] p;
      if (last != (mbin == 255)) begin
         mbin = 0;
         mframe = 0;
         return;
      end
      rw = 79'(re);
      iw = 79'(im);
      p = 79'(rw * rw + iw * iw);
      if (mframe == 0) begin
         sum_m[mbin] = p;
         max_m[mbin] = p;
      end else begin
         sum_m[mbin] = sum_m[mbin] + p;
         if (p > max_m[mbin]) max_m[mbin] = p;
      end
      if (mframe == 3) begin
         q0.push_back({mbin == 255, fmt(sum_m[mbin] >> 2, 32, 0, 1'b0)});
         q1.push_back({mbin == 255, fmt(max_m[mbin], 32, 0, 1'b1)});
         q2.push_back({mbin == 255, fmt(sum_m[mbin] >> 2, 8, 2, 1'b0)});
      end
      if (mbin == 255) begin
         mbin = 0;
         mframe = (mframe + 1) % 4;
      end else mbin++;
   endtask

   task automatic send(input logic signed [37:0] re, input logic signed [37:0] im, input logic last);
      int tmo;
      @(posedge clk); #1;
      tdata = {im, re};
      tvalid = 1'b1;
      tlast = last;
      tmo = 0;
      @(negedge clk);
      while (!b0.s_axis_tready) begin
         if (++tmo > 2000) begin
            chk("s_tready_timeout", 64'(b0.s_axis_tready), 64'd1);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $fatal(1, "FAIL s_axis_tready never returned");
         end
         @(negedge clk);
      end
      model_accept(re, im, last);
   endtask

   task automatic send_frame(input int pat, input int n, input int tl);
      logic signed [37:0] re, im;
      for (int b = 0; b < n; b++) begin
         case (pat)
            0: begin re = 3; im = 4; end
            1: begin re = (b == 7) ? 10 : 3; im = (b == 7) ? 0 : 4; end
            2: begin re = 100; im = 100; end
            default: begin
               re = 38'(int'($urandom_range(0, 2097152)) - 1048576);
               im = 38'(int'($urandom_range(0, 2097152)) - 1048576);
            end
         endcase
         send(re, im, b == tl);
         if (b == 0) acc0 = cyc;
      end
   endtask

   task automatic drain(input int n);
      @(posedge clk); #1;
      tvalid = 1'b0;
      tlast = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_set(input string tag, input int base);
      drain(10);
      chk({tag, "_beats"}, 64'(out_cnt - base), 64'd256);
      chk({tag, "_q0_empty"}, 64'(q0.size()), 64'd0);
      chk({tag, "_q1_empty"}, 64'(q1.size()), 64'd0);
      chk({tag, "_q2_empty"}, 64'(q2.size()), 64'd0);
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n) begin
         if (fe0) err_cnt++;
         if (b0.m_axis_tvalid && m_tready) begin
            if (first_cyc < 0) first_cyc = cyc;
            out_cnt++;
            if (b0.m_axis_tlast) last_cnt++;
            chk("u0_expected_beat", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
               chk("u0_data", 64'(b0.m_axis_tdata), 64'(q0[0][31:0]));
               chk("u0_last", 64'(b0.m_axis_tlast), 64'(q0[0][32]));
               void'(q0.pop_front());
            end
         end
         if (b1.m_axis_tvalid && m_tready) begin
            chk("u1_expected_beat", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
               chk("u1_data", 64'(b1.m_axis_tdata), 64'(q1[0][31:0]));
               chk("u1_last", 64'(b1.m_axis_tlast), 64'(q1[0][32]));
               void'(q1.pop_front());
            end
         end
         if (b2.m_axis_tvalid && m_tready) begin
            chk("u2_expected_beat", 64'(q2.size() != 0), 64'd1);
            if (q2.size() != 0) begin
               chk("u2_data", 64'(b2.m_axis_tdata), 64'(q2[0][7:0]));
               chk("u2_last", 64'(b2.m_axis_tlast), 64'(q2[0][32]));
               void'(q2.pop_front());
            end
         end
      end
   end

   initial begin
      int base;
      logic [31:0] held;
      rst_n = 1'b0; clear = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0; m_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", 64'(b0.m_axis_tvalid), 64'd0);
      chk("rst_m_tlast", 64'(b0.m_axis_tlast), 64'd0);
      chk("rst_frame_err", 64'(fe0), 64'd0);
      chk("rst_s_tready", 64'(b0.s_axis_tready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rel_s_tready_low", 64'(b0.s_axis_tready), 64'd0);
      @(posedge clk); #1;
      chk("rel_s_tready_high", 64'(b0.s_axis_tready), 64'd1);

      // constant 3/4 data; no output until the fourth frame
      base = out_cnt;
      for (int f = 0; f < 3; f++) send_frame(0, 256, 255);
      drain(5);
      chk("no_output_frames_1_3", 64'(out_cnt - base), 64'd0);
      first_cyc = -1;
      send_frame(0, 256, 255);
      check_set("mean", base);
      chk("latency", 64'(first_cyc - acc0), 64'd3);
      chk("tlast_count", 64'(last_cnt), 64'd1);

      // one louder bin in frame 2: peak-hold keeps 100, mean gives 43
      base = out_cnt;
      send_frame(0, 256, 255);
      send_frame(1, 256, 255);
      send_frame(0, 256, 255);
      send_frame(0, 256, 255);
      check_set("peak", base);

      // saturating and random power, with a 10-cycle output stall mid-frame
      base = out_cnt;
      send_frame(2, 256, 255);
      for (int f = 0; f < 2; f++) send_frame(3, 256, 255);
      fork
         send_frame(3, 256, 255);
         begin
            for (int t = 0; t < 3000 && out_cnt < base + 100; t++) @(negedge clk);
            @(posedge clk); #1;
            m_tready = 1'b0;
            #1;
            chk("stall_s_tready", 64'(b0.s_axis_tready), 64'd0);
            held = b0.m_axis_tdata;
            repeat (10) @(posedge clk);
            #1;
            chk("stall_hold_valid", 64'(b0.m_axis_tvalid), 64'd1);
            chk("stall_hold_data", 64'(b0.m_axis_tdata), 64'(held));
            m_tready = 1'b1;
         end
      join
      check_set("stall", base);

      // early tlast on bin 99 of frame 2 aborts the set
      base = out_cnt;
      send_frame(3, 256, 255);
      send_frame(3, 100, 99);
      drain(5);
      chk("early_tlast_err", 64'(err_cnt), 64'd1);
      chk("aborted_no_output", 64'(out_cnt - base), 64'd0);
      for (int f = 0; f < 4; f++) send_frame(3, 256, 255);
      check_set("after_early", base);

      // missing tlast on bin 255
      send_frame(3, 256, -1);
      drain(5);
      chk("missing_tlast_err", 64'(err_cnt), 64'd2);

      // clear together with a beat: beat dropped, no frame_err
      base = out_cnt;
      send_frame(3, 256, 255);
      send_frame(3, 30, -1);
      @(posedge clk); #1;
      tdata = {38'sd9, 38'sd9};
      tvalid = 1'b1;
      clear = 1'b1;
      mbin = 0;
      mframe = 0;
      @(posedge clk); #1;
      clear = 1'b0;
      tvalid = 1'b0;
      for (int f = 0; f < 4; f++) send_frame(3, 256, 255);
      check_set("after_clear", base);
      chk("clear_no_err", 64'(err_cnt), 64'd2);

      // reset during the emitted frame
      for (int f = 0; f < 3; f++) send_frame(0, 256, 255);
      send_frame(0, 53, -1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      tvalid = 1'b0;
      #1;
      chk("rst_mid_emit_valid", 64'(b0.m_axis_tvalid), 64'd0);
      q0.delete(); q1.delete(); q2.delete();
      mbin = 0;
      mframe = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      base = out_cnt;
      @(posedge clk); #1;
      chk("rst2_s_tready", 64'(b0.s_axis_tready), 64'd1);
      for (int f = 0; f < 4; f++) send_frame(3, 256, 255);
      check_set("after_reset", base);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
